// File: rtl/mp_add_seq.sv
// Multi-precision add sequencer: one 4-bit ripple slice reused once per nibble, carry kept in a flop.
// Optional subtract mode (port sub) is compiled in when MP_ADD_SEQ_SUB_EN is defined.
module mp_add_seq #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef MP_ADD_SEQ_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             busy
);

    localparam int unsigned NSLICE = WIDTH / 4;
    localparam int unsigned IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               carry_q, carry_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic               cout_q, cout_d;
    logic               ovf_q, ovf_d;

    logic [WIDTH-1:0]   b_in;
    logic               c_in;
    logic [3:0]         a_nib;
    logic [3:0]         b_nib;
    logic [4:0]         slice_res;
    logic               last_step;

    // Subtraction is a + ~b + ~cin, so the slice itself never changes.
`ifdef MP_ADD_SEQ_SUB_EN
    assign b_in = sub ? ~b : b;
    assign c_in = sub ? ~cin : cin;
`else
    assign b_in = b;
    assign c_in = cin;
`endif

    always_comb begin
        a_nib = '0;
        b_nib = '0;
        for (int i = 0; i < int'(NSLICE); i++) begin
            if (idx_q == IDX_W'(i)) begin
                a_nib = a_q[4*i +: 4];
                b_nib = b_q[4*i +: 4];
            end
        end
        slice_res = {1'b0, a_nib} + {1'b0, b_nib} + {4'b0000, carry_q};
        last_step = (idx_q == IDX_W'(NSLICE - 1));
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;

        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b_in;
                    carry_d = c_in;
                    idx_d   = '0;
                    state_d = StRun;
                end
            end
            StRun: begin
                for (int i = 0; i < int'(NSLICE); i++) begin
                    if (idx_q == IDX_W'(i)) begin
                        sum_d[4*i +: 4] = slice_res[3:0];
                    end
                end
                carry_d = slice_res[4];
                idx_d   = idx_q + IDX_W'(1);
                if (last_step) begin
                    cout_d  = slice_res[4];
                    // Carry into the MSB recovered from the MSB's sum bit and its inputs.
                    ovf_d   = slice_res[3] ^ a_nib[3] ^ b_nib[3] ^ slice_res[4];
                    idx_d   = '0;
                    state_d = StDone;
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            idx_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        in_ready  = (state_q == StIdle);
        busy      = (state_q == StRun);
        out_valid = (state_q == StDone);
        sum       = sum_q;
        cout      = cout_q;
        ovf       = ovf_q;
    end

endmodule

// File: tb/tb_mp_add_seq.sv
// Bench for mp_add_seq: directed steps plus random operands checked against an arithmetic model.
module tb_mp_add_seq;

    localparam int W  = 16;
    localparam int NS = W / 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
`ifdef MP_ADD_SEQ_SUB_EN
    logic         sub;
`endif
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    logic         busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mp_add_seq #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
`ifdef MP_ADD_SEQ_SUB_EN
        .sub       (sub),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf),
        .busy      (busy)
    );

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Result = {ovf, cout, sum} from plain integer arithmetic and the signed-overflow rule.
    function automatic logic [W+1:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                           input logic mc, input logic ms);
        logic [W-1:0] bb;
        logic [W:0]   full;
        logic         v;
        bb   = ms ? ~mb : mb;
        full = {1'b0, ma} + {1'b0, bb} + {{W{1'b0}}, ms ? ~mc : mc};
        v    = (ma[W-1] == bb[W-1]) && (full[W-1] != ma[W-1]);
        return {v, full};
    endfunction

    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tc,
                          input logic ts, input int stall, input string tag);
        logic [W+1:0] m;
        int           edges;
        int           busy_cnt;
        m = model(ta, tb, tc, ts);
        a = ta;
        b = tb;
        cin = tc;
`ifdef MP_ADD_SEQ_SUB_EN
        sub = ts;
`endif
        out_ready = (stall == 0);
        in_valid = 1'b1;
        chk({tag, "_in_ready_idle"}, W'(in_ready), W'(1));
        step();
        in_valid = 1'b0;
        edges = 1;
        busy_cnt = int'(busy);
        while (!out_valid && edges < 20) begin
            step();
            edges++;
            busy_cnt += int'(busy);
        end
        chk({tag, "_latency"}, W'(edges), W'(NS + 1));
        chk({tag, "_busy_cycles"}, W'(busy_cnt), W'(NS));
        chk({tag, "_sum"}, sum, m[W-1:0]);
        chk({tag, "_cout"}, W'(cout), W'(m[W]));
        chk({tag, "_ovf"}, W'(ovf), W'(m[W+1]));
        for (int k = 0; k < stall; k++) begin
            // Operands offered while the result is held must be ignored.
            in_valid = k[0];
            a = W'($urandom);
            b = W'($urandom);
            cin = 1'($urandom);
            step();
            chk({tag, "_hold_valid"}, W'(out_valid), W'(1));
            chk({tag, "_hold_in_ready"}, W'(in_ready), W'(0));
            chk({tag, "_hold_sum"}, sum, m[W-1:0]);
            chk({tag, "_hold_cout"}, W'(cout), W'(m[W]));
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        step();
        chk({tag, "_post_valid"}, W'(out_valid), W'(0));
        chk({tag, "_post_in_ready"}, W'(in_ready), W'(1));
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        a = '0;
        b = '0;
        cin = 1'b0;
`ifdef MP_ADD_SEQ_SUB_EN
        sub = 1'b0;
`endif
        out_ready = 1'b1;
        step();
        step();
        chk("rst_in_ready", W'(in_ready), W'(1));
        chk("rst_out_valid", W'(out_valid), W'(0));
        chk("rst_busy", W'(busy), W'(0));
        chk("rst_sum", sum, W'(0));
        chk("rst_cout", W'(cout), W'(0));
        chk("rst_ovf", W'(ovf), W'(0));
        rst = 1'b0;
        step();

        run_op(16'h0008, 16'h0007, 1'b0, 1'b0, 0, "small");
        run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 0, "wrap");
        run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 0, "sovf");
        run_op(16'h0FFF, 16'h0000, 1'b1, 1'b0, 0, "chain");
        run_op(16'h1357, 16'h2468, 1'b0, 1'b0, 10, "bp");
        run_op(16'h0101, 16'h0202, 1'b0, 1'b0, 0, "after_bp");

        // Reset in the second RUN cycle abandons the operation.
        a = 16'h1234;
        b = 16'h1111;
        cin = 1'b0;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mid_rst_in_ready", W'(in_ready), W'(1));
        chk("mid_rst_busy", W'(busy), W'(0));
        chk("mid_rst_out_valid", W'(out_valid), W'(0));
        chk("mid_rst_sum", sum, W'(0));
        chk("mid_rst_cout", W'(cout), W'(0));
        chk("mid_rst_ovf", W'(ovf), W'(0));
        for (int k = 0; k < 6; k++) begin
            step();
            chk("mid_rst_no_valid", W'(out_valid), W'(0));
        end
        run_op(16'h0003, 16'h0004, 1'b0, 1'b0, 0, "post_rst");

        // Reset wins over a simultaneous in_valid.
        rst = 1'b1;
        in_valid = 1'b1;
        step();
        rst = 1'b0;
        in_valid = 1'b0;
        chk("rst_vs_valid_busy", W'(busy), W'(0));
        chk("rst_vs_valid_in_ready", W'(in_ready), W'(1));

`ifdef MP_ADD_SEQ_SUB_EN
        run_op(16'h000B, 16'h0005, 1'b0, 1'b1, 0, "sub_pos");
        run_op(16'h0005, 16'h000B, 1'b0, 1'b1, 0, "sub_neg");
        run_op(16'h8000, 16'h0001, 1'b0, 1'b1, 0, "sub_ovf");
`endif

        for (int n = 0; n < 20; n++) begin
            logic ts;
`ifdef MP_ADD_SEQ_SUB_EN
            ts = 1'($urandom);
`else
            ts = 1'b0;
`endif
            run_op(W'($urandom), W'($urandom), 1'($urandom), ts, int'($urandom_range(0, 3)),
                   "rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
